// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Brings up the on-chip PLL and owns the reset of every domain clocked from
// it. Runs on the PLL reference clock, which is alive before the PLL output.
// Sequence: pulse the PLL reset, wait for lock (with timeout and retry),
// require lock to hold for a stable window, then release the system reset and
// keep watching lock for the rest of operation.
//
// Optional feature macro: PLL_SEQ_AUTO_RECOVER_EN
//   defined   : a lock loss in RUN restarts the full sequence from PLL_RST.
//   undefined : a lock loss in RUN parks in FAULT until reset is asserted.
//
// Ports
//   clk             in   PLL reference clock
//   reset           in   asynchronous, active-high
//   pll_lock        in   PLL LOCK output, asynchronous to clk
//   pll_reset       out  PLL RESET input, active-high (high only in PLL_RST)
//   sys_reset       out  active-high reset for PLL-clocked logic (low only in RUN)
//   ready           out  locked and stable; always the inverse of sys_reset
//   lock_loss_count out  lock drops seen in RUN, saturating at 255
//   timeout_err     out  sticky flag, set by any lock timeout
//
// Handshakes: none. pll_lock is a level that is sampled through a two-flop
// synchronizer; every output is a registered level.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_loss_count,
    output logic       timeout_err
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                  : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sync_q;
    logic             lock_s;
    logic             set_terr;
    logic             inc_loss;
    logic             counting;

    // Next-state decision. The lock test is ahead of the counter test in
    // STABLE, so a drop on the final stable cycle goes back to WAIT_LOCK.
    always_comb begin
        state_nxt = state;
        set_terr  = 1'b0;
        inc_loss  = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    set_terr  = 1'b1;
                    state_nxt = ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                   state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST)   state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    inc_loss = 1'b1;
`ifdef PLL_SEQ_AUTO_RECOVER_EN
                    state_nxt = ST_PLL_RST;
`else
                    state_nxt = ST_FAULT;
`endif
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                // Unreachable encodings restart the sequence from the top.
                state_nxt = ST_PLL_RST;
            end
        endcase
    end

    // Only the three timed states advance the shared counter.
    assign counting = (state == ST_PLL_RST) || (state == ST_WAIT_LOCK) ||
                      (state == ST_STABLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q          <= 1'b0;
            lock_s          <= 1'b0;
            state           <= ST_PLL_RST;
            cnt             <= '0;
            pll_reset       <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
            timeout_err     <= 1'b0;
        end else begin
            sync_q <= pll_lock;
            lock_s <= sync_q;
            state  <= state_nxt;

            // Counter restarts from 0 on every state entry.
            if (state_nxt != state) cnt <= '0;
            else if (counting)      cnt <= cnt + CNT_W'(1);

            // Outputs follow the state being entered so they change on the
            // same edge as the state itself.
            pll_reset <= (state_nxt == ST_PLL_RST);
            sys_reset <= (state_nxt != ST_RUN);
            ready     <= (state_nxt == ST_RUN);

            if (set_terr) timeout_err <= 1'b1;
            if (inc_loss && (lock_loss_count != 8'hFF))
                lock_loss_count <= lock_loss_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32,
// LOCK_STABLE_CYCLES=8. pll_lock changes on the falling edge; outputs are
// read on the falling edge. The reference model tracks the sequencer as a
// phase plus the edge number at which that phase was entered, and sees the
// lock pin through a two-entry delay queue.
module tb_pll_lock_sequencer;

    localparam int PR = 4;
    localparam int LT = 32;
    localparam int LS = 8;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    // reference model state
    int       n_edge;
    int       m_phase;
    int       m_since;
    int       m_loss;
    bit       m_terr;
    bit       pin_q[$];

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (PR),
        .LOCK_TIMEOUT_CYCLES (LT),
        .LOCK_STABLE_CYCLES  (LS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .pll_reset       (pll_reset),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .timeout_err     (timeout_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic model_reset();
        n_edge  = 0;
        m_phase = P_RST;
        m_since = 0;
        m_loss  = 0;
        m_terr  = 1'b0;
        pin_q.delete();
        pin_q.push_back(1'b0);
        pin_q.push_back(1'b0);
    endtask

    // Called at a falling edge; leaves time at a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- reference model ----------------
    task automatic enter(input int ph);
        m_phase = ph;
        m_since = n_edge;
    endtask

    task automatic model_edge(input bit pin);
        bit ls;
        int age;
        ls = pin_q.pop_front();
        pin_q.push_back(pin);
        n_edge++;
        age = n_edge - m_since;
        case (m_phase)
            P_RST:    if (age == PR) enter(P_WAIT);
            P_WAIT: begin
                if (ls) enter(P_STABLE);
                else if (age == LT) begin
                    m_terr = 1'b1;
                    enter(P_RST);
                end
            end
            P_STABLE: begin
                if (!ls) enter(P_WAIT);
                else if (age == LS) enter(P_RUN);
            end
            P_RUN: begin
                if (!ls) begin
                    if (m_loss < 255) m_loss++;
`ifdef PLL_SEQ_AUTO_RECOVER_EN
                    enter(P_RST);
`else
                    enter(P_FAULT);
`endif
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [11:0] exp_vec();
        logic run;
        run = (m_phase == P_RUN);
        return {(m_phase == P_RST), !run, run, m_terr, 8'(m_loss)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {pll_reset, sys_reset, ready, timeout_err, lock_loss_count};
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input bit pin);
        pll_lock = pin;
        @(posedge clk);
        model_edge(pin);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 12'hC00) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", dut_vec(), 12'hC00);
        end
        for (int i = 1; i <= PR + 2; i++) begin
            cyc(1'b0);
            checks++;
            if (pll_reset !== (i < PR)) begin
                failures++;
                $display("FAIL pll_reset_width edge=%0d got=%b exp=%b", i, pll_reset, (i < PR));
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_reset edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_lock_latency();
        int k;
        int d;
        do_reset();
        d = $urandom_range(0, 10);
        for (int i = 0; i < PR + d; i++) cyc(1'b0);
        for (k = 1; k <= 30; k++) begin
            cyc(1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_latency edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
            if (!sys_reset) break;
        end
        checks++;
        if (k != LS + 3 || ready !== 1'b1) begin
            failures++;
            $display("FAIL lock_latency got_edge=%0d ready=%b exp_edge=%0d", k, ready, LS + 3);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 2 * (PR + LT) + 2; i++) begin
            cyc(1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_timeout edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
            if (i == PR + LT - 1 || i == PR + LT) begin
                checks++;
                if (timeout_err !== (i == PR + LT) || pll_reset !== (i == PR + LT)) begin
                    failures++;
                    $display("FAIL timeout_edge edge=%0d terr=%b pll_reset=%b exp=%b",
                             i, timeout_err, pll_reset, (i == PR + LT));
                end
            end
            if (i == 2 * PR + LT || i == 2 * (PR + LT)) begin
                checks++;
                if (pll_reset !== (i == 2 * (PR + LT)) || timeout_err !== 1'b1) begin
                    failures++;
                    $display("FAIL timeout_retry edge=%0d pll_reset=%b terr=%b", i, pll_reset, timeout_err);
                end
            end
        end
    endtask

    // Lock drop seen by STABLE while its counter is 5: release must wait a
    // fresh full window after relock.
    task automatic test_stable_drop();
        int rel;
        rel = 0;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            cyc(!(i <= PR || (i >= 11 && i <= 13)));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_stable_drop edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
            if (rel == 0 && !sys_reset) rel = i;
        end
        checks++;
        if (rel != 24) begin
            failures++;
            $display("FAIL stable_drop_release got_edge=%0d exp_edge=24", rel);
        end
    endtask

    task automatic test_run_drop();
        int k;
        do_reset();
        for (k = 1; k <= 40; k++) begin
            cyc(1'b1);
            if (ready) break;
        end
        for (k = 1; k <= 10; k++) begin
            cyc(1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_run_drop edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
            if (sys_reset) break;
        end
        checks++;
        if (k != 3 || lock_loss_count !== 8'd1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL run_drop_latency got_edge=%0d count=%0d exp_edge=3 exp_count=1", k, lock_loss_count);
        end
`ifdef PLL_SEQ_AUTO_RECOVER_EN
        for (k = 1; k <= 40; k++) begin
            cyc(1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_relock edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
            if (ready) break;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL relock got_ready=%b exp=1", ready);
        end
`else
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_fault edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (sys_reset !== 1'b1 || pll_reset !== 1'b0 || lock_loss_count !== 8'd1) begin
            failures++;
            $display("FAIL fault_hold sys_reset=%b pll_reset=%b count=%0d exp=1/0/1",
                     sys_reset, pll_reset, lock_loss_count);
        end
`endif
    endtask

`ifdef PLL_SEQ_AUTO_RECOVER_EN
    task automatic test_saturation();
        int k;
        do_reset();
        for (int d = 0; d < 260; d++) begin
            for (k = 1; k <= 60; k++) begin
                cyc(1'b1);
                if (ready) break;
            end
            if (!ready) begin
                checks++;
                failures++;
                $display("FAIL saturation_relock drop=%0d got_ready=%b", d, ready);
                break;
            end
            repeat (3) cyc(1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_saturation edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (lock_loss_count !== 8'd255) begin
            failures++;
            $display("FAIL saturation got=%0d exp=255", lock_loss_count);
        end
    endtask
`endif

    task automatic test_random();
        int len;
        bit val;
        do_reset();
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            len = $urandom_range(1, 45);
            val = 1'($urandom_range(0, 2) != 0);
            for (int i = 0; i < len; i++) begin
                cyc(val);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL model_random edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        for (int i = 0; i < PR + LT; i++) cyc(1'b0);
        for (k = 1; k <= 40; k++) begin
            cyc(1'b1);
            if (ready) break;
        end
        checks++;
        if (ready !== 1'b1 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL async_setup ready=%b terr=%b exp=1/1", ready, timeout_err);
        end
        // Assert reset mid-cycle and look before the next rising edge.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 12'hC00) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), 12'hC00);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        // Counter and synchronizer must restart from zero.
        for (int i = 0; i < PR + 12; i++) begin
            cyc(1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL model_after_reset edge=%0d got=%h exp=%h", n_edge, dut_vec(), exp_vec());
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        model_reset();
        test_reset();
        test_lock_latency();
        test_timeout();
        test_stable_drop();
        test_run_drop();
`ifdef PLL_SEQ_AUTO_RECOVER_EN
        test_saturation();
`endif
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
